// File: rtl/cpu_pkg.sv
// cpu_pkg: shared memory-stage types and encodings.
// Holds the controller state enum, the size encodings and the word-alignment mask.
package cpu_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;
    localparam logic       SIZE_WORD  = 1'b0;
    localparam logic       SIZE_BYTE  = 1'b1;
    localparam logic [1:0] ALIGN_MASK = 2'b11;
endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: combinational byte-lane steering for stores and loads.
// Ports: size (1 = byte), lane (addr[1:0]), wdata_in/wdata_out (store path),
//        rdata_in/rdata_out (load path, byte lane zero-extended).
module byte_lane_unit
    import cpu_pkg::*;
(
    input  logic        size,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);
    assign wdata_out = (size == SIZE_BYTE) ? {4{wdata_in[7:0]}} : wdata_in;
    assign rdata_out = (size == SIZE_BYTE) ? {24'd0, rdata_in[{lane, 3'b000} +: 8]} : rdata_in;
endmodule

// File: rtl/mem_stage_controller.sv
// mem_stage_controller: sequences MEM-stage loads/stores over a req/ack memory port.
// Ports: clk, rst_n (async, active-low); decoder side req_valid, load_instr,
//        Size_enable, addr, store_data, rd_in; stall to the pipeline; memory side
//        mem_req/mem_we/mem_size/mem_addr/mem_wdata out, mem_ack/mem_rdata in;
//        write-back wb_valid/wb_rd/wb_data; error pulses align_err, timeout_err.
module mem_stage_controller
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        load_instr,
    input  logic        Size_enable,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [3:0]  rd_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        align_err,
    output logic        timeout_err
);
    state_t      state, next_state;
    logic        load_q, size_q, err_q, align_q;
    logic [31:0] addr_q, data_q, rdata_q, lane_wdata, lane_rdata;
    logic [3:0]  rd_q;
    logic [7:0]  cnt;
    logic        misaligned, limit, accept;

    assign misaligned = req_valid & (Size_enable == SIZE_WORD) & ((addr[1:0] & ALIGN_MASK) != 2'b00);
    // Limit is hit when this REQ cycle would be the TIMEOUT_CYCLES-th without an ack.
    assign limit      = (cnt + 8'd1) == 8'(TIMEOUT_CYCLES);
    // Gated with rst_n so stall drops immediately while reset is held.
    assign accept     = rst_n & (state == IDLE) & req_valid & ~misaligned;
    assign align_err  = align_q;

    byte_lane_unit u_lane (
        .size     (size_q),
        .lane     (addr_q[1:0]),
        .wdata_in (data_q),
        .rdata_in (rdata_q),
        .wdata_out(lane_wdata),
        .rdata_out(lane_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        stall       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_size    = 1'b0;
        mem_addr    = 32'd0;
        mem_wdata   = 32'd0;
        wb_valid    = 1'b0;
        wb_rd       = 4'd0;
        wb_data     = 32'd0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                stall      = accept;
                next_state = accept ? REQ : IDLE;
            end
            REQ: begin
                stall      = 1'b1;
                mem_req    = 1'b1;
                mem_we     = ~load_q;
                mem_size   = size_q;
                mem_addr   = addr_q;
                mem_wdata  = load_q ? 32'd0 : lane_wdata;
                next_state = (mem_ack || limit) ? DONE : REQ;
            end
            DONE: begin
                wb_valid    = load_q & ~err_q;
                wb_rd       = wb_valid ? rd_q : 4'd0;
                wb_data     = wb_valid ? lane_rdata : 32'd0;
                timeout_err = err_q;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q  <= 1'b0;
            size_q  <= 1'b0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            rd_q    <= 4'd0;
            rdata_q <= 32'd0;
            cnt     <= 8'd0;
            err_q   <= 1'b0;
            align_q <= 1'b0;
        end else begin
            align_q <= (state == IDLE) & misaligned;
            if (accept) begin
                load_q <= load_instr;
                size_q <= Size_enable;
                addr_q <= addr;
                data_q <= store_data;
                rd_q   <= rd_in;
                cnt    <= 8'd0;
                err_q  <= 1'b0;
            end
            if (state == REQ) begin
                cnt <= cnt + 8'd1;
                if (mem_ack)    rdata_q <= mem_rdata;
                else if (limit) err_q   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_controller.sv
// tb_mem_stage_controller: directed self-checking bench for mem_stage_controller.
module tb_mem_stage_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, load_instr = 1'b0, Size_enable = 1'b0;
    logic [31:0] addr = 32'd0, store_data = 32'd0;
    logic [3:0]  rd_in = 4'd0;
    logic        stall, mem_req, mem_we, mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        align_err, timeout_err;
    int          checks = 0;
    int          errors = 0;

    mem_stage_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .load_instr(load_instr),
        .Size_enable(Size_enable), .addr(addr), .store_data(store_data), .rd_in(rd_in),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .align_err(align_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        chk({tag, ".mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, ".mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, ".mem_size"}, 32'(mem_size), 32'd0);
        chk({tag, ".mem_addr"}, mem_addr, 32'd0);
        chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, ".wb_rd"}, 32'(wb_rd), 32'd0);
        chk({tag, ".wb_data"}, wb_data, 32'd0);
        chk({tag, ".align_err"}, 32'(align_err), 32'd0);
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic issue(input logic ld, input logic sz, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] rd);
        req_valid = 1'b1; load_instr = ld; Size_enable = sz; addr = a; store_data = d; rd_in = rd;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        // word load, zero-wait memory
        @(negedge clk); issue(1'b1, 1'b0, 32'h100, 32'h0, 4'd3);
        #1 chk("wl.c0.stall", 32'(stall), 32'd1);
        chk("wl.c0.mem_req", 32'(mem_req), 32'd0);
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1 chk("wl.c1.mem_req", 32'(mem_req), 32'd1);
        chk("wl.c1.mem_we", 32'(mem_we), 32'd0);
        chk("wl.c1.mem_addr", mem_addr, 32'h100);
        chk("wl.c1.stall", 32'(stall), 32'd1);
        @(negedge clk); mem_ack = 1'b0;
        #1 chk("wl.c2.wb_valid", 32'(wb_valid), 32'd1);
        chk("wl.c2.wb_rd", 32'(wb_rd), 32'd3);
        chk("wl.c2.wb_data", wb_data, 32'hDEADBEEF);
        chk("wl.c2.stall", 32'(stall), 32'd0);
        @(negedge clk); req_valid = 1'b0;
        #1 chk("wl.c3.wb_valid", 32'(wb_valid), 32'd0);
        chk("wl.c3.stall", 32'(stall), 32'd0);

        // byte load, lane 2, ack in the limit cycle
        @(negedge clk); issue(1'b1, 1'b1, 32'h102, 32'h0, 4'd5);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); req_valid = 1'b0;
            #1 chk($sformatf("bl.c%0d.mem_req", c), 32'(mem_req), 32'd1);
            chk($sformatf("bl.c%0d.mem_size", c), 32'(mem_size), 32'd1);
        end
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h11223344;
        #1 chk("bl.c4.mem_req", 32'(mem_req), 32'd1);
        chk("bl.c4.mem_size", 32'(mem_size), 32'd1);
        @(negedge clk); mem_ack = 1'b0;
        #1 chk("bl.c5.wb_valid", 32'(wb_valid), 32'd1);
        chk("bl.c5.wb_data", wb_data, 32'h00000022);
        chk("bl.c5.wb_rd", 32'(wb_rd), 32'd5);
        chk("bl.c5.timeout_err", 32'(timeout_err), 32'd0);

        // byte store, replication
        @(negedge clk); issue(1'b0, 1'b1, 32'h201, 32'h000000A5, 4'd0);
        @(negedge clk); req_valid = 1'b0; mem_ack = 1'b1;
        #1 chk("bs.c1.mem_we", 32'(mem_we), 32'd1);
        chk("bs.c1.mem_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("bs.c1.mem_addr", mem_addr, 32'h201);
        @(negedge clk); mem_ack = 1'b0;
        #1 chk("bs.c2.wb_valid", 32'(wb_valid), 32'd0);
        chk("bs.c2.stall", 32'(stall), 32'd0);

        // misaligned word store
        @(negedge clk); issue(1'b0, 1'b0, 32'h203, 32'h12345678, 4'd0);
        #1 chk("ma.c0.stall", 32'(stall), 32'd0);
        @(negedge clk); req_valid = 1'b0;
        #1 chk("ma.c1.align_err", 32'(align_err), 32'd1);
        chk("ma.c1.mem_req", 32'(mem_req), 32'd0);
        chk("ma.c1.stall", 32'(stall), 32'd0);
        @(negedge clk);
        #1 chk("ma.c2.align_err", 32'(align_err), 32'd0);

        // timeout with no ack
        @(negedge clk); issue(1'b1, 1'b0, 32'h300, 32'h0, 4'd9);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); req_valid = 1'b0;
            #1 chk($sformatf("to.c%0d.mem_req", c), 32'(mem_req), 32'd1);
        end
        @(negedge clk);
        #1 chk("to.c5.mem_req", 32'(mem_req), 32'd0);
        chk("to.c5.timeout_err", 32'(timeout_err), 32'd1);
        chk("to.c5.wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        #1 chk("to.c6.timeout_err", 32'(timeout_err), 32'd0);

        // word load acked in the limit cycle
        @(negedge clk); issue(1'b1, 1'b0, 32'h304, 32'h0, 4'd6);
        repeat (3) begin
            @(negedge clk); req_valid = 1'b0;
        end
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1 chk("ta.c4.mem_req", 32'(mem_req), 32'd1);
        @(negedge clk); mem_ack = 1'b0;
        #1 chk("ta.c5.timeout_err", 32'(timeout_err), 32'd0);
        chk("ta.c5.wb_valid", 32'(wb_valid), 32'd1);
        chk("ta.c5.wb_data", wb_data, 32'hCAFEF00D);

        // reset mid-access
        @(negedge clk); issue(1'b0, 1'b0, 32'h400, 32'h55AA55AA, 4'd0);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        #1 chk("rm.c2.mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1 chk_all_zero("rm.async");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); issue(1'b1, 1'b0, 32'h104, 32'h0, 4'd7);
        @(negedge clk); req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
        #1 chk("rf.c1.mem_addr", mem_addr, 32'h104);
        @(negedge clk); mem_ack = 1'b0;
        #1 chk("rf.c2.wb_valid", 32'(wb_valid), 32'd1);
        chk("rf.c2.wb_rd", 32'(wb_rd), 32'd7);
        chk("rf.c2.wb_data", wb_data, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage_controller.md
# mem_stage_controller

Sequencer for the pipeline's memory stage: it takes a decoded load/store from the MEM stage, drives a multi-cycle request/acknowledge access to data memory, stalls the pipeline until the access completes, and hands load results to write-back. It sits between the decoder's memory-control outputs (`load_instr`, `Size_enable`, `Enable_signal`) and the data-memory port. It owns byte-lane steering, alignment checking and a bounded wait on memory.

## Interface

- `TIMEOUT_CYCLES`, default 15: maximum number of cycles spent in REQ without `mem_ack` before the access is abandoned. Legal range 1–255.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: the MEM-stage instruction is a memory operation (decoder `Enable_signal`).
- `load_instr` in 1: 1 = load, 0 = store.
- `Size_enable` in 1: 1 = byte, 0 = word.
- `addr` in 32: effective address.
- `store_data` in 32: Rd value for stores.
- `rd_in` in 4: load destination register.
- `stall` out 1: holds the IF/ID/EX/MEM pipeline registers.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write enable.
- `mem_size` out 1: 1 = byte, 0 = word.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_ack` in 1: memory completes the access this cycle.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `wb_valid` out 1: one-cycle load-result strobe.
- `wb_rd` out 4: load destination register.
- `wb_data` out 32: load result.
- `align_err` out 1: one-cycle pulse for a misaligned word access.
- `timeout_err` out 1: one-cycle pulse when an access is abandoned.

## Operation

- FSM states are IDLE, REQ and DONE.
- **IDLE**
  - `req_valid` = 1 with a word access and `addr[1:0]` ≠ 0: pulse `align_err` next cycle, issue no request, stay in IDLE.
  - `req_valid` = 1 otherwise: latch op, size, `addr`, `store_data` and `rd_in`, then go to REQ.
- **REQ**
  - Outputs: `mem_req` = 1, `mem_we` = ~load, `mem_size` = size, `mem_addr` = latched address.
  - Word store: `mem_wdata` = data.
  - Byte store: `mem_wdata` = `{4{data[7:0]}}`.
  - `mem_ack` = 1: latch `mem_rdata`, go to DONE.
  - Otherwise the wait counter increments. When it equals `TIMEOUT_CYCLES`, go to DONE with the error flag set.
  - `mem_ack` in the same cycle as the limit: the ack wins and no error is raised.
- **DONE** (exactly one cycle, then IDLE)
  - Successful load: `wb_valid` = 1 and `wb_rd` = latched `rd_in`.
  - Word load: `wb_data` = rdata.
  - Byte load: little-endian lane `rdata[8*addr[1:0] +: 8]`, zero-extended to 32 bits.
  - Stores: `wb_valid` = 0.
  - Timeout: `timeout_err` = 1, `wb_valid` = 0.
- **`stall`** is combinational: (IDLE & `req_valid` & ~misaligned) | REQ. It is 0 in DONE. The MEM stage advances at the end of DONE, so `req_valid` is ignored in DONE.
- **Reset** (asserted at any time, including mid-access): state IDLE, counter 0. Every output is 0: `stall`, `mem_req`, `mem_we`, `mem_size`, `mem_addr`, `mem_wdata`, `wb_valid`, `wb_rd`, `wb_data`, `align_err`, `timeout_err`. An in-flight request is dropped without acknowledgement.

## Timing

- Cycle 0: IDLE samples `req_valid`; `stall` = 1 in the same cycle.
- Cycle 1: `mem_req` = 1 (registered).
- With `mem_ack` in cycle k ≥ 1: DONE in cycle k+1 (`wb_valid`, `stall` = 0). The next instruction can be accepted in cycle k+2.
- Zero-wait memory (ack in cycle 1): 3-cycle occupancy, 2 stall cycles.
- Timeout: `mem_req` stays high for exactly `TIMEOUT_CYCLES` cycles (cycles 1 … `TIMEOUT_CYCLES`). DONE with `timeout_err` follows in the next cycle.
- `align_err` is registered: it rises the cycle after the misaligned `req_valid`, and `stall` is never asserted for that access.
- `mem_addr`, `mem_wdata`, `mem_we` and `mem_size` are held stable while `mem_req` = 1.
- The wait counter is 8 bits and clears on entry to REQ.

## Structure

- Shared package `cpu_pkg` holds:
  - the state enum (IDLE = 2'b00, REQ = 2'b01, DONE = 2'b10);
  - the size encodings `SIZE_WORD` = 1'b0 and `SIZE_BYTE` = 1'b1;
  - the word-alignment mask 2'b11.
- One natural sub-module, `byte_lane_unit`, which is combinational and shared by the load and store paths. It performs store byte replication and load lane extraction with zero-extension.
- FSM, counter and latches live in `mem_stage_controller`.

## Test plan

- Word load: `addr` = 0x100, `rd_in` = 4'd3, `mem_ack` in cycle 1 with rdata 0xDEADBEEF → `wb_valid` in cycle 2 with `wb_rd` = 3 and `wb_data` = 0xDEADBEEF. `stall` is high in cycles 0–1 only.
- Byte load: `addr` = 0x102, rdata 0x11223344, 3 wait cycles → `wb_data` = 0x00000022. `mem_size` = 1 throughout REQ.
- Byte store: `addr` = 0x201, `store_data` = 0x000000A5 → `mem_we` = 1 and `mem_wdata` = 0xA5A5A5A5 during REQ. No `wb_valid`.
- Misaligned word store: `addr` = 0x203 → `align_err` pulses in cycle 1. `mem_req` and `stall` stay 0.
- Timeout: `TIMEOUT_CYCLES` = 4, no ack → `mem_req` high in cycles 1–4, `timeout_err` in cycle 5, `wb_valid` = 0. Repeat with ack in cycle 4 → normal completion, no error.
- Reset mid-access: `rst_n` low in cycle 2 of REQ → all outputs 0 immediately (asynchronously). After release, a fresh load completes normally.
